// File: rtl/spike_output_arbiter.sv
// Round-robin serializer for LIF spike pulses into a show-ahead output FIFO.
// Ports: clk, rst_n, enable, clear, spike_vec in; spike_out_valid/neuron_id/weight,
//   spike_out_ready in; fifo_full, busy, overflow, drop_count, out_count status.
//   Optional SPIKE_TIMESTAMP_EN adds timestep_tick in, spike_out_timestamp out.
module spike_output_arbiter #(
    parameter int NUM_NEURONS     = 64,
    parameter int NEURON_ID_WIDTH = 8,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int OUT_WEIGHT      = 100,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [NUM_NEURONS-1:0]     spike_vec,
`ifdef SPIKE_TIMESTAMP_EN
    input  logic                       timestep_tick,
    output logic [15:0]                spike_out_timestamp,
`endif
    output logic                       spike_out_valid,
    output logic [NEURON_ID_WIDTH-1:0] spike_out_neuron_id,
    output logic [WEIGHT_WIDTH-1:0]    spike_out_weight,
    input  logic                       spike_out_ready,
    output logic                       fifo_full,
    output logic                       busy,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    output logic [31:0]                out_count
);

    localparam int PTR_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PC_W  = $clog2(NUM_NEURONS) + 1;
`ifdef SPIKE_TIMESTAMP_EN
    localparam int ENT_W = NEURON_ID_WIDTH + 16;
`else
    localparam int ENT_W = NEURON_ID_WIDTH;
`endif

    logic [NUM_NEURONS-1:0] pending;
    logic [PTR_W-1:0]       rr_ptr;
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [AW:0]            fill;
    logic [ENT_W-1:0]       mem [FIFO_DEPTH];
    logic [ENT_W-1:0]       head;
    logic [ENT_W-1:0]       entry;

    logic                   empty;
    logic                   pop;
    logic                   found;
    logic                   grant;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       search_idx;
    logic [NUM_NEURONS-1:0] grant_mask;
    logic [NUM_NEURONS-1:0] cap;
    logic [NUM_NEURONS-1:0] drop_vec;
    logic [PC_W-1:0]        drop_n;
    logic [16:0]            drop_sum;

    assign fill      = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign fifo_full = fill[AW];
    assign pop       = !empty && spike_out_ready;
    assign head      = mem[rd_ptr[AW-1:0]];

    assign spike_out_valid     = !empty;
    assign spike_out_neuron_id = empty ? '0 : head[NEURON_ID_WIDTH-1:0];
    assign spike_out_weight    = WEIGHT_WIDTH'(OUT_WEIGHT);
    assign busy                = (|pending) || !empty;

    // First set pending bit at or after rr_ptr, wrapping modulo NUM_NEURONS.
    always_comb begin
        found      = 1'b0;
        grant_idx  = '0;
        search_idx = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            search_idx = rr_ptr + PTR_W'(i);
            if (!found && pending[search_idx]) begin
                found     = 1'b1;
                grant_idx = search_idx;
            end
        end
    end

    // A full FIFO can still accept a push when the head leaves this cycle.
    assign grant = found && (!fifo_full || pop);

    always_comb begin
        grant_mask = '0;
        if (grant) grant_mask[grant_idx] = 1'b1;
    end

    assign cap      = enable ? spike_vec : '0;
    // A bit being granted this cycle re-arms instead of coalescing.
    assign drop_vec = cap & pending & ~grant_mask;

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_NEURONS; i++)
            drop_n = drop_n + PC_W'(drop_vec[i]);
    end

    assign drop_sum = {1'b0, drop_count} + 17'(drop_n);

`ifdef SPIKE_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             ts_cnt <= '0;
        else if (clear)         ts_cnt <= '0;
        else if (timestep_tick) ts_cnt <= ts_cnt + 16'd1;
    end

    // Pre-increment value is captured when a tick lands on the grant cycle.
    assign entry = {ts_cnt, NEURON_ID_WIDTH'(grant_idx)};
    assign spike_out_timestamp = empty ? '0 : head[ENT_W-1:NEURON_ID_WIDTH];
`else
    assign entry = NEURON_ID_WIDTH'(grant_idx);
`endif

    always_ff @(posedge clk) begin
        if (grant && !clear) mem[wr_ptr[AW-1:0]] <= entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            out_count  <= '0;
        end else if (clear) begin
            pending    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            out_count  <= '0;
        end else begin
            pending <= (pending & ~grant_mask) | cap;
            if (grant) begin
                rr_ptr <= grant_idx + PTR_W'(1);
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                out_count <= out_count + 32'd1;
            end
            if (|drop_vec) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

endmodule
